// File: rtl/wb_queue.sv
// wb_queue: register-file write-back queue with store-to-read forwarding.
//   Two write-back sources (ALU and memory/load) push {addr, val} pairs into a
//   circular FIFO. One entry is popped per cycle into a registered write port.
//   Reads can snoop every pending write, including the one in the output
//   register, and get the youngest value for their address.
// Ports:
//   Clk, Rst                : clock, asynchronous active-high reset
//   AEn, AAddr, AVal        : ALU write-back request
//   MEn, MAddr, MVal        : load write-back request
//   Stall                   : fewer than two free entries; sources must hold
//   WEn, WAddr, WVal        : registered register-file write port
//   RAddr1/2                : read addresses to look up
//   FwdHit1/2, FwdVal1/2    : forwarding result per read port
//   Count                   : occupied queue entries
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       AEn,
  input  logic [4:0]                 AAddr,
  input  logic [31:0]                AVal,
  input  logic                       MEn,
  input  logic [4:0]                 MAddr,
  input  logic [31:0]                MVal,
  output logic                       Stall,
  output logic                       WEn,
  output logic [4:0]                 WAddr,
  output logic [31:0]                WVal,
  input  logic [4:0]                 RAddr1,
  input  logic [4:0]                 RAddr2,
  output logic                       FwdHit1,
  output logic                       FwdHit2,
  output logic [31:0]                FwdVal1,
  output logic [31:0]                FwdVal2,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   val_q  [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          a_ok, m_ok, pop;
  logic [PW-1:0] m_slot;

  // Stall only depends on occupancy, so both sources can be accepted whenever
  // it is low without looking at this cycle's pop.
  assign Stall = (count_q > CW'(DEPTH - 2));
  assign Count = count_q;

  assign a_ok   = AEn && !Stall && (AAddr != 5'd0);
  assign m_ok   = MEn && !Stall && (MAddr != 5'd0);
  assign pop    = (count_q != '0);
  // The load entry lands behind the ALU entry when both are accepted.
  assign m_slot = tail_q + PW'(a_ok);

  always_ff @(posedge Clk) begin
    if (a_ok) begin
      addr_q[tail_q] <= AAddr;
      val_q[tail_q]  <= AVal;
    end
    if (m_ok) begin
      addr_q[m_slot] <= MAddr;
      val_q[m_slot]  <= MVal;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      WEn     <= 1'b0;
      WAddr   <= 5'd0;
      WVal    <= 32'd0;
    end else begin
      tail_q  <= tail_q + PW'(a_ok) + PW'(m_ok);
      head_q  <= head_q + PW'(pop);
      count_q <= count_q + CW'(a_ok) + CW'(m_ok) - CW'(pop);
      WEn     <= pop;
      if (pop) begin
        WAddr <= addr_q[head_q];
        WVal  <= val_q[head_q];
      end
    end
  end

  // Scan oldest to youngest so the last match wins: output register first,
  // then queue entries from head towards tail-1.
  always_comb begin
    logic [PW-1:0] idx;
    FwdHit1 = 1'b0;
    FwdHit2 = 1'b0;
    FwdVal1 = 32'd0;
    FwdVal2 = 32'd0;
    idx     = '0;
    if (WEn && RAddr1 != 5'd0 && WAddr == RAddr1) begin
      FwdHit1 = 1'b1;
      FwdVal1 = WVal;
    end
    if (WEn && RAddr2 != 5'd0 && WAddr == RAddr2) begin
      FwdHit2 = 1'b1;
      FwdVal2 = WVal;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (RAddr1 != 5'd0 && addr_q[idx] == RAddr1) begin
          FwdHit1 = 1'b1;
          FwdVal1 = val_q[idx];
        end
        if (RAddr2 != 5'd0 && addr_q[idx] == RAddr2) begin
          FwdHit2 = 1'b1;
          FwdVal2 = val_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized and directed bench for wb_queue against a
// queue-based reference model of the write-back behaviour.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        Clk, Rst;
  logic        AEn, MEn;
  logic [4:0]  AAddr, MAddr, RAddr1, RAddr2, WAddr;
  logic [31:0] AVal, MVal, WVal, FwdVal1, FwdVal2;
  logic        Stall, WEn, FwdHit1, FwdHit2;
  logic [$clog2(DEPTH):0] Count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wval;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .AEn(AEn), .AAddr(AAddr), .AVal(AVal),
    .MEn(MEn), .MAddr(MAddr), .MVal(MVal),
    .Stall(Stall), .WEn(WEn), .WAddr(WAddr), .WVal(WVal),
    .RAddr1(RAddr1), .RAddr2(RAddr2),
    .FwdHit1(FwdHit1), .FwdHit2(FwdHit2),
    .FwdVal1(FwdVal1), .FwdVal2(FwdVal2),
    .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] fwd(input logic [4:0] r);
    logic [32:0] res;
    res = 33'd0;
    if (r != 5'd0) begin
      if (m_wen && m_waddr == r) res = {1'b1, m_wval};
      foreach (mq[i]) if (mq[i].a == r) res = {1'b1, mq[i].v};
    end
    return res;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wen   = 1'b0;
    m_waddr = 5'd0;
    m_wval  = 32'd0;
  endtask

  task automatic check_all();
    logic [32:0] f1, f2;
    f1 = fwd(RAddr1);
    f2 = fwd(RAddr2);
    chk("stall",  {31'd0, Stall}, {31'd0, (DEPTH - mq.size()) < 2});
    chk("count",  {29'd0, Count}, mq.size());
    chk("wen",    {31'd0, WEn},   {31'd0, m_wen});
    chk("waddr",  {27'd0, WAddr}, {27'd0, m_waddr});
    chk("wval",   WVal,           m_wval);
    chk("hit1",   {31'd0, FwdHit1}, {31'd0, f1[32]});
    chk("fval1",  FwdVal1,        f1[31:0]);
    chk("hit2",   {31'd0, FwdHit2}, {31'd0, f2[32]});
    chk("fval2",  FwdVal2,        f2[31:0]);
  endtask

  // One clock: drive at negedge, check settled outputs, advance model at posedge.
  task automatic cyc(input logic ae, input logic [4:0] aa, input logic [31:0] av,
                     input logic me, input logic [4:0] ma, input logic [31:0] mv,
                     input logic [4:0] r1, input logic [4:0] r2);
    bit st;
    @(negedge Clk);
    AEn = ae; AAddr = aa; AVal = av;
    MEn = me; MAddr = ma; MVal = mv;
    RAddr1 = r1; RAddr2 = r2;
    #1;
    check_all();
    @(posedge Clk);
    if (Rst) begin
      model_reset();
    end else begin
      st = (DEPTH - mq.size()) < 2;
      if (mq.size() > 0) begin
        ent_t e;
        e = mq.pop_front();
        m_wen = 1'b1; m_waddr = e.a; m_wval = e.v;
      end else begin
        m_wen = 1'b0;
      end
      if (!st && ae && aa != 5'd0) mq.push_back('{a: aa, v: av});
      if (!st && me && ma != 5'd0) mq.push_back('{a: ma, v: mv});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    AEn = 0; AAddr = 0; AVal = 0; MEn = 0; MAddr = 0; MVal = 0;
    RAddr1 = 0; RAddr2 = 0;
    model_reset();
    Rst = 1'b1;
    #1;
    chk("rst_wen",   {31'd0, WEn},   0);
    chk("rst_count", {29'd0, Count}, 0);
    chk("rst_stall", {31'd0, Stall}, 0);
    #11 Rst = 1'b0;

    // single write
    cyc(1, 5, 32'h1234, 0, 0, 0, 0, 0);
    #1 chk("single_cnt", {29'd0, Count}, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("single_wen", {31'd0, WEn}, 1);
    chk("single_addr", {27'd0, WAddr}, 5);
    chk("single_val", WVal, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("single_wen_off", {31'd0, WEn}, 0);

    // same-cycle ordering, forwarding youngest
    cyc(1, 3, 32'hA, 1, 3, 32'hB, 3, 0);
    #1 chk("order_fwd", FwdVal1, 32'hB);
    cyc(0, 0, 0, 0, 0, 0, 3, 0);
    #1 chk("order_first", WVal, 32'hA);
    chk("order_fwd2", FwdVal1, 32'hB);
    cyc(0, 0, 0, 0, 0, 0, 3, 0);
    #1 chk("order_second", WVal, 32'hB);
    idle(2);

    // address zero dropped
    cyc(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
    #1 chk("zero_cnt", {29'd0, Count}, 0);
    chk("zero_hit", {31'd0, FwdHit1}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("zero_wen", {31'd0, WEn}, 0);

    // stall under continuous dual pushes
    for (int k = 0; k < 8; k++) begin
      cyc(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (k == 1) begin
        #1 chk("stall_hi", {31'd0, Stall}, 1);
      end
    end
    idle(6);

    // wrap-around with drains
    for (int k = 0; k < 12; k++) begin
      cyc(1, 5'(k + 1), 32'h100 + k, 0, 0, 0, 5'(k + 1), 0);
      idle(k % 3);
    end
    idle(4);
    #1 chk("wrap_empty", {29'd0, Count}, 0);

    // async reset with pending entries
    cyc(1, 7, 32'h70, 1, 8, 32'h80, 0, 0);
    cyc(1, 9, 32'h90, 1, 10, 32'h91, 0, 0);
    #1 chk("pre_rst_cnt", {29'd0, Count}, 3);
    #2 AEn = 0; MEn = 0; RAddr1 = 9;
    Rst = 1'b1;
    #1;
    chk("arst_wen",   {31'd0, WEn},   0);
    chk("arst_count", {29'd0, Count}, 0);
    chk("arst_hit",   {31'd0, FwdHit1}, 0);
    chk("arst_stall", {31'd0, Stall}, 0);
    model_reset();
    @(negedge Clk);
    #2 Rst = 1'b0;
    idle(4);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
